// File: rtl/bcd_tick_counter_pkg.sv
// Shared types and constants for the two-digit BCD tick counter: digit width,
// active-low seven-segment patterns and anode encodings.
package bcd_tick_counter_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;
    typedef logic [6:0]         seg_t;   // {g,f,e,d,c,b,a}, active-low

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_LUT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        AN_UNITS = 2'b10,
        AN_TENS  = 2'b01
    } an_t;

    function automatic bcd_t bcd_sat(input bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_tick_counter_if.sv
// Control, count and display signals of the BCD tick counter; the master side
// drives tick/controls, the slave side (the counter) drives count and display.
interface bcd_tick_counter_if;

    logic       tick_in;
    logic       run;
    logic       up;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output tick_in, run, up, clear, load, load_val,
        input  count, wrap, seg, an
    );

    modport slave (
        input  tick_in, run, up, clear, load, load_val,
        output count, wrap, seg, an
    );

endinterface

// File: rtl/bcd_tick_counter_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder; non-BCD codes blank the digit.
module seg7_decoder
    import bcd_tick_counter_pkg::*;
(
    input  bcd_t i_bcd,
    output seg_t o_seg
);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = SEG_LUT[0];
            4'd1: o_seg = SEG_LUT[1];
            4'd2: o_seg = SEG_LUT[2];
            4'd3: o_seg = SEG_LUT[3];
            4'd4: o_seg = SEG_LUT[4];
            4'd5: o_seg = SEG_LUT[5];
            4'd6: o_seg = SEG_LUT[6];
            4'd7: o_seg = SEG_LUT[7];
            4'd8: o_seg = SEG_LUT[8];
            4'd9: o_seg = SEG_LUT[9];
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of an asynchronous tick,
// with a registered, time-multiplexed active-low seven-segment display.
module bcd_tick_counter
    import bcd_tick_counter_pkg::*;
#(
    parameter int SCAN_W   = 10,
    parameter int SYNC_LEN = 2
) (
    input  logic                clk_in,
    input  logic                rst,
    bcd_tick_counter_if.slave   bus
);

    logic [SYNC_LEN-1:0] r_sync;
    logic                r_hist;
    logic [SYNC_LEN:0]   r_fill;
    logic                w_sync_out;
    logic                w_tick;

    bcd_t r_units, r_tens;
    logic r_wrap;
    bcd_t w_units_nxt, w_tens_nxt;
    logic w_wrap_nxt;

    logic [SCAN_W-1:0] r_scan;
    logic              r_digit;
    an_t               r_an;
    seg_t              r_seg;
    bcd_t              w_digit_bcd;
    seg_t              w_seg;

    // Ticks are suppressed until the chain holds real samples, so a tick_in
    // already high when reset lifts is not mistaken for a rising edge.
    assign w_sync_out = r_sync[SYNC_LEN-1];
    assign w_tick     = w_sync_out & ~r_hist & r_fill[SYNC_LEN];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_LEN-2:0], bus.tick_in};
            r_hist <= w_sync_out;
            r_fill <= {r_fill[SYNC_LEN-1:0], 1'b1};
        end
    end

    always_comb begin
        w_units_nxt = r_units;
        w_tens_nxt  = r_tens;
        w_wrap_nxt  = 1'b0;
        if (bus.clear) begin
            w_units_nxt = 4'd0;
            w_tens_nxt  = 4'd0;
        end else if (bus.load) begin
            w_units_nxt = bcd_sat(bus.load_val[3:0]);
            w_tens_nxt  = bcd_sat(bus.load_val[7:4]);
        end else if (bus.run && w_tick) begin
            if (bus.up) begin
                if (r_units == 4'd9) begin
                    w_units_nxt = 4'd0;
                    w_tens_nxt  = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
                    w_wrap_nxt  = (r_tens == 4'd9);
                end else begin
                    w_units_nxt = r_units + 4'd1;
                end
            end else begin
                if (r_units == 4'd0) begin
                    w_units_nxt = 4'd9;
                    w_tens_nxt  = (r_tens == 4'd0) ? 4'd9 : r_tens - 4'd1;
                    w_wrap_nxt  = (r_tens == 4'd0);
                end else begin
                    w_units_nxt = r_units - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_units <= 4'd0;
            r_tens  <= 4'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_units <= w_units_nxt;
            r_tens  <= w_tens_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // r_digit flips each time the scan counter rolls over, holding each digit for 2**SCAN_W cycles.
    assign w_digit_bcd = r_digit ? r_tens : r_units;

    seg7_decoder u_seg7 (
        .i_bcd (w_digit_bcd),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_scan  <= '0;
            r_digit <= 1'b0;
            r_an    <= AN_UNITS;
            r_seg   <= SEG_LUT[0];
        end else begin
            r_scan <= r_scan + 1'b1;
            if (&r_scan) begin
                r_digit <= ~r_digit;
            end
            r_an  <= r_digit ? AN_TENS : AN_UNITS;
            r_seg <= w_seg;
        end
    end

    assign bus.count = {r_tens, r_units};
    assign bus.wrap  = r_wrap;
    assign bus.an    = r_an;
    assign bus.seg   = r_seg;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter: expected count/wrap values are queued as
// stimulus is driven and popped by a monitor whenever the count changes.
module tb_bcd_tick_counter;

    localparam int SCAN_W   = 3;
    localparam int SYNC_LEN = 2;

    typedef struct packed {
        logic [7:0] count;
        logic       wrap;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    always #5 clk_in = ~clk_in;

    bcd_tick_counter_if bus ();

    bcd_tick_counter #(
        .SCAN_W   (SCAN_W),
        .SYNC_LEN (SYNC_LEN)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_count = 8'h00;
    logic [7:0] prev_count;
    bit         mon_en  = 1'b0;

    function automatic logic [8:0] model_step(input logic [7:0] c, input logic dir_up);
        int v;
        logic w;
        v = int'(c[7:4]) * 10 + int'(c[3:0]);
        v = dir_up ? (v + 1) % 100 : (v + 99) % 100;
        w = dir_up ? (v == 0) : (v == 99);
        return {w, 4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] model_sat(input logic [7:0] lv);
        logic [3:0] u, t;
        u = (lv[3:0] > 4'd9) ? 4'd9 : lv[3:0];
        t = (lv[7:4] > 4'd9) ? 4'd9 : lv[7:4];
        return {t, u};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Monitor: every count change must match the next queued expectation.
    always @(negedge clk_in) begin
        if (mon_en) begin
            n_tests++;
            if (bus.count[3:0] > 4'd9 || bus.count[7:4] > 4'd9) begin
                n_fail++;
                $display("FAIL nibble_range: count=%h exceeds BCD", bus.count);
            end
            if (bus.count !== prev_count) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: count %h -> %h with nothing expected", prev_count, bus.count);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.count !== e.count || bus.wrap !== e.wrap) begin
                        n_fail++;
                        $display("FAIL scoreboard: got count=%h wrap=%b, expected count=%h wrap=%b",
                                 bus.count, bus.wrap, e.count, e.wrap);
                    end
                end
            end else if (bus.wrap !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wrap_idle: wrap=%b with count unchanged at %h, expected 0", bus.wrap, bus.count);
            end
            prev_count = bus.count;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        logic [7:0] nv;
        nv = model_sat(v);
        bus.load_val = v;
        bus.load     = 1'b1;
        if (nv !== m_count) sb.push_back('{count: nv, wrap: 1'b0});
        m_count = nv;
        step();
        bus.load = 1'b0;
    endtask

    task automatic push_tick();
        logic [8:0] r;
        if (bus.run) begin
            r = model_step(m_count, bus.up);
            sb.push_back('{count: r[7:0], wrap: r[8]});
            m_count = r[7:0];
        end
    endtask

    task automatic do_tick(input int h, input int l);
        push_tick();
        bus.tick_in = 1'b1;
        repeat (h) step();
        bus.tick_in = 1'b0;
        repeat (l) step();
    endtask

    task automatic wait_count(input string name, input logic [7:0] exp, input int budget);
        int k = 0;
        while (bus.count !== exp && k < budget) begin
            step();
            k++;
        end
        check8(name, bus.count, exp);
    endtask

    task automatic resync();
        sb.delete();
        m_count    = 8'h00;
        prev_count = bus.count;
        mon_en     = 1'b1;
    endtask

    task automatic test_reset();
        bus.run = 1'b0;
        do_load(8'h23);
        step();
        check8("pre_reset_count", bus.count, 8'h23);
        @(posedge clk_in);
        #3;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check8("reset_count", bus.count, 8'h00);
        check8("reset_wrap", {7'd0, bus.wrap}, 8'h00);
        check8("reset_an", {6'd0, bus.an}, 8'h02);
        check8("reset_seg", {1'b0, bus.seg}, {1'b0, seg_of(0)});
        repeat (3) @(posedge clk_in);
        resync();
        @(negedge clk_in);
        rst = 1'b1;
    endtask

    // Entered straight after reset release: edge k is the k-th edge out of reset.
    task automatic test_scan();
        logic [1:0] exp_an;
        bus.load_val = 8'h37;
        bus.load     = 1'b1;
        sb.push_back('{count: 8'h37, wrap: 1'b0});
        m_count = 8'h37;
        for (int k = 1; k <= 40; k++) begin
            step();
            bus.load = 1'b0;
            exp_an = (((k - 1) / 8) % 2 == 1) ? 2'b01 : 2'b10;
            check8("scan_an", {6'd0, bus.an}, {6'd0, exp_an});
            if (k >= 2)
                check8("scan_seg", {1'b0, bus.seg}, {1'b0, seg_of(exp_an == 2'b10 ? 7 : 3)});
        end
    endtask

    task automatic test_latency();
        bus.run = 1'b1;
        bus.up  = 1'b1;
        do_load(8'h05);
        step();
        push_tick();
        bus.tick_in = 1'b1;
        step();
        check8("latency_edge1", bus.count, 8'h05);
        step();
        check8("latency_edge2", bus.count, 8'h05);
        step();
        check8("latency_edge3", bus.count, 8'h06);
        repeat (100) step();
        check8("latency_held_high", bus.count, 8'h06);
        bus.tick_in = 1'b0;
        repeat (3) step();
    endtask

    task automatic tick_expect_wrap(input string name, input logic [7:0] exp);
        push_tick();
        bus.tick_in = 1'b1;
        wait_count(name, exp, 10);
        check8({name, "_wrap_hi"}, {7'd0, bus.wrap}, 8'h01);
        step();
        check8({name, "_wrap_lo"}, {7'd0, bus.wrap}, 8'h00);
        bus.tick_in = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_wrap();
        bus.run = 1'b1;
        bus.up  = 1'b1;
        do_load(8'h98);
        do_tick(3, 3);
        check8("wrap_up_99", bus.count, 8'h99);
        tick_expect_wrap("wrap_up_00", 8'h00);
        bus.up = 1'b0;
        tick_expect_wrap("wrap_down_99", 8'h99);
    endtask

    task automatic test_priority();
        bus.run = 1'b1;
        bus.up  = 1'b1;
        bus.tick_in = 1'b1;
        step();
        step();
        bus.clear    = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 8'h42;
        sb.push_back('{count: 8'h00, wrap: 1'b0});
        m_count = 8'h00;
        step();
        bus.clear   = 1'b0;
        bus.load    = 1'b0;
        bus.tick_in = 1'b0;
        check8("prio_clear", bus.count, 8'h00);
        repeat (6) step();
        check8("prio_tick_lost", bus.count, 8'h00);
        do_load(8'hAF);
        check8("load_sat_AF", bus.count, 8'h99);
        do_load(8'h3C);
        check8("load_sat_3C", bus.count, 8'h39);
        bus.run = 1'b0;
        do_tick(4, 4);
        check8("run0_hold", bus.count, 8'h39);
        bus.run = 1'b1;
        repeat (10) step();
        check8("run0_no_deferred", bus.count, 8'h39);
    endtask

    task automatic test_random();
        for (int b = 0; b < 25; b++) begin
            bus.run = ($urandom_range(0, 3) != 0);
            bus.up  = $urandom_range(0, 1) == 1;
            repeat (4) do_tick(int'($urandom_range(1, 25)), int'($urandom_range(1, 25)));
            repeat (4) step();
        end
        repeat (6) step();
        check8("random_final", bus.count, m_count);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: %0d expected changes never seen, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_tick();
        @(posedge clk_in);
        #3;
        mon_en      = 1'b0;
        rst         = 1'b0;
        bus.tick_in = 1'b1;
        bus.run     = 1'b1;
        bus.up      = 1'b1;
        repeat (3) @(posedge clk_in);
        resync();
        @(negedge clk_in);
        rst = 1'b1;
        repeat (20) step();
        check8("reset_tick_high_ignored", bus.count, 8'h00);
        bus.tick_in = 1'b0;
        repeat (3) step();
        do_tick(3, 3);
        check8("reset_tick_next_edge", bus.count, 8'h01);
    endtask

    initial begin
        bus.tick_in  = 1'b0;
        bus.run      = 1'b0;
        bus.up       = 1'b1;
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 8'h00;
        repeat (3) @(posedge clk_in);
        resync();
        @(negedge clk_in);
        rst = 1'b1;
        repeat (4) step();
        test_reset();
        test_scan();
        test_latency();
        test_wrap();
        test_priority();
        test_random();
        test_reset_tick();
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
